// File: rtl/gpu_launch_ctrl.sv
// Board-level gpu launch controller: reset sequencing, debounced start button,
// start/done handshake, run statistics and LED map. Optional watchdog: GPU_LAUNCH_TIMEOUT_EN.
module gpu_launch_ctrl #(
    parameter int NUM_LEDS          = 8,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int CYCLE_W           = 32,
    parameter int RUN_CNT_W         = 8,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_start,
    input  logic                 sw_continuous,
    input  logic                 execution_done,
    output logic                 gpu_reset,
    output logic                 execution_start,
    output logic                 busy,
    output logic [CYCLE_W-1:0]   last_cycles,
    output logic [RUN_CNT_W-1:0] run_count,
    output logic [NUM_LEDS-1:0]  leds
);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [DEB_W-1:0]     DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]     DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
    localparam logic [CYCLE_W-1:0]   CYC_ONE   = CYCLE_W'(1);
    localparam logic [CYCLE_W-1:0]   CYC_MAX   = {CYCLE_W{1'b1}};
    localparam logic [RUN_CNT_W-1:0] RUN_ONE   = RUN_CNT_W'(1);
    localparam logic [RUN_CNT_W-1:0] RUN_MAX   = {RUN_CNT_W{1'b1}};
`ifdef GPU_LAUNCH_TIMEOUT_EN
    localparam logic [CYCLE_W-1:0]   TIMEOUT_VAL = CYCLE_W'(TIMEOUT_CYCLES);
`endif

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RUNNING = 3'd2,
        ST_DONE    = 3'd3,
`ifdef GPU_LAUNCH_TIMEOUT_EN
        ST_ERROR   = 3'd5,
`endif
        ST_REARM   = 3'd4
    } state_t;

    // Refuse parameterisations the LED map and counters cannot represent.
    if (NUM_LEDS < 4 || RESET_HOLD_CYCLES < 1 || DEBOUNCE_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1 || RUN_CNT_W < NUM_LEDS - 3) begin : g_param_check
        $error("gpu_launch_ctrl: illegal parameter combination");
    end

    logic                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic                 deb_level_q, deb_level_d, press_q, press_d;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CYCLE_W-1:0]   cyc_cnt_q, cyc_cnt_d, last_cycles_q, last_cycles_d;
    logic [RUN_CNT_W-1:0] run_count_q, run_count_d;
    logic                 gpu_reset_q, gpu_reset_d, start_q, start_d;
    logic                 busy_q, busy_d, err_q, err_d;
    logic [NUM_LEDS-1:0]  leds_q, leds_d;

    // Button path: two-flop synchroniser, then a level flips only after a full run of disagreeing samples.
    always_comb begin
        sync1_d     = btn_start;
        sync2_d     = sync1_q;
        deb_level_d = deb_level_q;
        deb_cnt_d   = {DEB_W{1'b0}};
        press_d     = 1'b0;
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = sync2_q;
                press_d     = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_ONE;
            end
        end else begin
            deb_cnt_d = {DEB_W{1'b0}};
        end
    end

    // Launch FSM plus run statistics; every output is registered from its next-state value.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cyc_cnt_d     = cyc_cnt_q;
        last_cycles_d = last_cycles_q;
        run_count_d   = run_count_q;
        gpu_reset_d   = gpu_reset_q;
        start_d       = start_q;
        err_d         = err_q;
        case (state_q)
            ST_HOLD, ST_REARM: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d  = {HOLD_W{1'b0}};
                    gpu_reset_d = 1'b0;
                    if (state_q == ST_REARM) begin
                        state_d   = ST_RUNNING;
                        start_d   = 1'b1;
                        cyc_cnt_d = CYC_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            ST_IDLE: begin
                if (press_q) begin
                    state_d   = ST_RUNNING;
                    start_d   = 1'b1;
                    cyc_cnt_d = CYC_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                if (execution_done) begin
                    state_d       = ST_DONE;
                    start_d       = 1'b0;
                    last_cycles_d = cyc_cnt_q;
                    run_count_d   = (run_count_q == RUN_MAX) ? run_count_q : run_count_q + RUN_ONE;
                end
`ifdef GPU_LAUNCH_TIMEOUT_EN
                else if (cyc_cnt_q == TIMEOUT_VAL) begin
                    state_d     = ST_ERROR;
                    start_d     = 1'b0;
                    gpu_reset_d = 1'b1;
                    err_d       = 1'b1;
                end
`endif
                else begin
                    cyc_cnt_d = (cyc_cnt_q == CYC_MAX) ? cyc_cnt_q : cyc_cnt_q + CYC_ONE;
                end
            end
            ST_DONE: begin
                if (sw_continuous || press_q) begin
                    state_d     = ST_REARM;
                    gpu_reset_d = 1'b1;
                    hold_cnt_d  = {HOLD_W{1'b0}};
                end else begin
                    state_d = ST_DONE;
                end
            end
`ifdef GPU_LAUNCH_TIMEOUT_EN
            ST_ERROR: begin
                if (press_q) begin
                    state_d    = ST_REARM;
                    err_d      = 1'b0;
                    hold_cnt_d = {HOLD_W{1'b0}};
                end else begin
                    state_d = ST_ERROR;
                end
            end
`endif
            default: begin
                state_d     = ST_HOLD;
                hold_cnt_d  = {HOLD_W{1'b0}};
                gpu_reset_d = 1'b1;
                start_d     = 1'b0;
                err_d       = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_RUNNING);
        leds_d = {run_count_d[NUM_LEDS-4:0], err_d, busy_d, (state_d == ST_DONE)};
    end

    // All storage; reset forces the gpu into reset and restarts the hold sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            deb_level_q   <= 1'b0;
            deb_cnt_q     <= {DEB_W{1'b0}};
            press_q       <= 1'b0;
            state_q       <= ST_HOLD;
            hold_cnt_q    <= {HOLD_W{1'b0}};
            cyc_cnt_q     <= {CYCLE_W{1'b0}};
            last_cycles_q <= {CYCLE_W{1'b0}};
            run_count_q   <= {RUN_CNT_W{1'b0}};
            gpu_reset_q   <= 1'b1;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            leds_q        <= {NUM_LEDS{1'b0}};
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_level_q   <= deb_level_d;
            deb_cnt_q     <= deb_cnt_d;
            press_q       <= press_d;
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cyc_cnt_q     <= cyc_cnt_d;
            last_cycles_q <= last_cycles_d;
            run_count_q   <= run_count_d;
            gpu_reset_q   <= gpu_reset_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            leds_q        <= leds_d;
        end
    end

    assign gpu_reset       = gpu_reset_q;
    assign execution_start = start_q;
    assign busy            = busy_q;
    assign last_cycles     = last_cycles_q;
    assign run_count       = run_count_q;
    assign leds            = leds_q;
endmodule
